// File: rtl/video_pkg.sv
// Shared types for the video pattern source.
package video_pkg;

  localparam int unsigned PAT_W = 2;
  localparam int unsigned GAP_W = 4;

  typedef enum logic [PAT_W-1:0] {DIAG, HRAMP, VRAMP, CHECK} pattern_t;

  typedef enum logic [1:0] {IDLE, ACTIVE, LGAP, FGAP} vps_state_t;

endpackage

// File: rtl/video_pattern_pix.sv
// Combinational pixel generator: maps (pattern, x, y) to a pixel value.
module video_pattern_pix
  import video_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned DIM_WIDTH   = 16
) (
  input  logic [PAT_W-1:0]       pattern_i,
  input  logic [DIM_WIDTH-1:0]   x_i,
  input  logic [DIM_WIDTH-1:0]   y_i,
  output logic [PIXEL_WIDTH-1:0] pix_c
);

  logic [DIM_WIDTH-1:0] sum;

  // Pattern select; the diagonal wraps naturally through truncation.
  always_comb begin
    sum   = x_i + y_i;
    pix_c = '0;
    case (pattern_t'(pattern_i))
      DIAG:    pix_c = PIXEL_WIDTH'(sum);
      HRAMP:   pix_c = PIXEL_WIDTH'(x_i);
      VRAMP:   pix_c = PIXEL_WIDTH'(y_i);
      CHECK:   pix_c = {PIXEL_WIDTH{x_i[3] ^ y_i[3]}};
      default: pix_c = '0;
    endcase
  end

endmodule

// File: rtl/video_pattern_src.sv
// Test-pattern video source producing pulse-sync de/hs/vs pixel streams.
module video_pattern_src
  import video_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned DIM_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [DIM_WIDTH-1:0]   img_w,
  input  logic [DIM_WIDTH-1:0]   img_h,
  input  logic [PAT_W-1:0]       pattern,
  input  logic [GAP_W-1:0]       de_gap,
  input  logic [DIM_WIDTH-1:0]   line_gap,
  input  logic [DIM_WIDTH-1:0]   frame_gap,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o,
  output logic                   busy_o,
  output logic                   frame_done_o
);

  vps_state_t           state_q, state_d;
  logic [DIM_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [GAP_W-1:0]     sc_q, sc_d;
  logic [DIM_WIDTH-1:0] gc_q, gc_d;
  logic [DIM_WIDTH-1:0] w_q, h_q, lg_q, fg_q;
  logic [GAP_W-1:0]     dg_q;
  pattern_t             pat_q;
  logic                 fend_q, fend_d;
  logic                 decide, cfg_ld, start_ok, pix_de;
  logic [PIXEL_WIDTH-1:0] pix;

  assign start_ok = en && (img_w != '0) && (img_h != '0);
  assign pix_de   = (state_q == ACTIVE) && (sc_q == '0);

  video_pattern_pix #(
    .PIXEL_WIDTH(PIXEL_WIDTH),
    .DIM_WIDTH  (DIM_WIDTH)
  ) u_pix (
    .pattern_i(pat_q),
    .x_i      (x_q),
    .y_i      (y_q),
    .pix_c    (pix)
  );

  // Next-state: pixel slots, line/frame gaps and the frame-start decision.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    sc_d    = sc_q;
    gc_d    = gc_q;
    fend_d  = 1'b0;
    decide  = 1'b0;
    cfg_ld  = 1'b0;
    case (state_q)
      IDLE: decide = 1'b1;
      ACTIVE: begin
        if (sc_q != dg_q) begin
          sc_d = sc_q + GAP_W'(1);
        end else begin
          sc_d = '0;
          if (x_q != w_q - DIM_WIDTH'(1)) begin
            x_d = x_q + DIM_WIDTH'(1);
          end else begin
            x_d = '0;
            if (y_q != h_q - DIM_WIDTH'(1)) begin
              y_d = y_q + DIM_WIDTH'(1);
              if (lg_q != '0) begin
                state_d = LGAP;
                gc_d    = lg_q - DIM_WIDTH'(1);
              end
            end else begin
              fend_d = 1'b1;
              if (fg_q == '0) begin
                decide = 1'b1;
              end else begin
                state_d = FGAP;
                gc_d    = fg_q - DIM_WIDTH'(1);
              end
            end
          end
        end
      end
      LGAP: begin
        if (gc_q == '0) state_d = ACTIVE;
        else            gc_d    = gc_q - DIM_WIDTH'(1);
      end
      FGAP: begin
        if (gc_q == '0) decide = 1'b1;
        else            gc_d   = gc_q - DIM_WIDTH'(1);
      end
      default: state_d = IDLE;
    endcase
    // Shared by IDLE and frame end: start a fresh frame or go idle.
    if (decide) begin
      if (start_ok) begin
        cfg_ld  = 1'b1;
        state_d = ACTIVE;
        x_d     = '0;
        y_d     = '0;
        sc_d    = '0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // State, counters and shadow configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      sc_q    <= '0;
      gc_q    <= '0;
      fend_q  <= 1'b0;
      w_q     <= '0;
      h_q     <= '0;
      lg_q    <= '0;
      fg_q    <= '0;
      dg_q    <= '0;
      pat_q   <= DIAG;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sc_q    <= sc_d;
      gc_q    <= gc_d;
      fend_q  <= fend_d;
      if (cfg_ld) begin
        w_q   <= img_w;
        h_q   <= img_h;
        lg_q  <= line_gap;
        fg_q  <= frame_gap;
        dg_q  <= de_gap;
        pat_q <= pattern_t'(pattern);
      end
    end
  end

  // Registered video outputs; pixel data holds between valid cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      do_o         <= '0;
      de_o         <= 1'b0;
      hs_o         <= 1'b0;
      vs_o         <= 1'b0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      if (pix_de) do_o <= pix;
      de_o         <= pix_de;
      hs_o         <= pix_de && (x_q == '0);
      vs_o         <= pix_de && (x_q == '0) && (y_q == '0);
      busy_o       <= (state_d != IDLE);
      frame_done_o <= fend_q;
    end
  end

endmodule

// File: tb/tb_video_pattern_src.sv
// Self-checking bench for video_pattern_src against an arithmetic frame model.
module tb_video_pattern_src;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] img_w, img_h, line_gap, frame_gap;
  logic [1:0]  pattern;
  logic [3:0]  de_gap;
  logic [7:0]  do_o;
  logic        de_o, hs_o, vs_o, busy_o, frame_done_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int w; int h; int pat; int dg; int lg; int fg;
  } cfg_t;

  video_pattern_src #(.PIXEL_WIDTH(8), .DIM_WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .img_w        (img_w),
    .img_h        (img_h),
    .pattern      (pattern),
    .de_gap       (de_gap),
    .line_gap     (line_gap),
    .frame_gap    (frame_gap),
    .do_o         (do_o),
    .de_o         (de_o),
    .hs_o         (hs_o),
    .vs_o         (vs_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic apply(input cfg_t c);
    img_w     = 16'(c.w);
    img_h     = 16'(c.h);
    pattern   = 2'(c.pat);
    de_gap    = 4'(c.dg);
    line_gap  = 16'(c.lg);
    frame_gap = 16'(c.fg);
  endtask

  function automatic cfg_t mk(input int w, h, pat, dg, lg, fg);
    cfg_t c;
    c.w = w; c.h = h; c.pat = pat; c.dg = dg; c.lg = lg; c.fg = fg;
    return c;
  endfunction

  function automatic cfg_t rnd_cfg();
    cfg_t c;
    c.w   = int'($urandom_range(20, 2));
    c.h   = int'($urandom_range(4, 1));
    c.pat = int'($urandom_range(3, 0));
    c.dg  = int'($urandom_range(3, 0));
    c.lg  = int'($urandom_range(3, 0));
    c.fg  = int'($urandom_range(4, 0));
    return c;
  endfunction

  // Expected {de, hs, vs, pixel} at cycle t after the frame's first pixel.
  function automatic logic [10:0] exp_vec(input cfg_t c, input int t);
    int slot, lp, act, x, y, r, pix;
    slot = c.dg + 1;
    lp   = c.w * slot + c.lg;
    act  = c.h * c.w * slot + (c.h - 1) * c.lg;
    if (t >= act) return 11'h0;
    y = t / lp;
    r = t % lp;
    if (r >= c.w * slot || (r % slot) != 0) return 11'h0;
    x = r / slot;
    case (c.pat)
      0:       pix = (x + y) & 255;
      1:       pix = x & 255;
      2:       pix = y & 255;
      default: pix = (((x >> 3) ^ (y >> 3)) & 1) != 0 ? 255 : 0;
    endcase
    return {1'b1, x == 0, (x == 0) && (y == 0), 8'(pix)};
  endfunction

  task automatic wait_vs(output int n);
    n = 0;
    while (vs_o !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("vs_wait", 32'(vs_o), 32'(1));
  endtask

  // Walk one whole frame period cycle by cycle; next config is presented at t=0.
  task automatic check_frame(input cfg_t c, input cfg_t nxt, input int drop_t, input bit prev_fg0);
    int   act, per, hs_cnt;
    logic exp_fd, exp_busy;
    act    = c.h * c.w * (c.dg + 1) + (c.h - 1) * c.lg;
    per    = act + c.fg;
    hs_cnt = 0;
    for (int t = 0; t < per; t++) begin
      chk("pixel", 32'({de_o, hs_o, vs_o, (de_o ? do_o : 8'h00)}), 32'(exp_vec(c, t)));
      exp_fd = (c.fg > 0 && t == act) || (t == 0 && prev_fg0);
      chk("frame_done", 32'(frame_done_o), 32'(exp_fd));
      exp_busy = !(t == per - 1 && drop_t >= 0);
      chk("busy", 32'(busy_o), 32'(exp_busy));
      if (hs_o) hs_cnt++;
      if (t == 0) apply(nxt);
      if (t == drop_t) en = 1'b0;
      @(negedge clk);
    end
    chk("hs_count", 32'(hs_cnt), 32'(c.h));
  endtask

  initial begin
    cfg_t cur, nxt, stop_c, rst_c;
    cfg_t dir[3];
    int   n;
    bit   prev_fg0;
    bit   any_de, any_busy, any_fd;

    rst_n = 1'b0;
    en    = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    chk("rst_do", 32'(do_o), 32'(0));
    chk("rst_de", 32'(de_o), 32'(0));
    chk("rst_hs", 32'(hs_o), 32'(0));
    chk("rst_vs", 32'(vs_o), 32'(0));
    chk("rst_busy", 32'(busy_o), 32'(0));
    chk("rst_fd", 32'(frame_done_o), 32'(0));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy_o), 32'(0));

    dir[0] = mk(4, 3, 0, 0, 2, 5);
    dir[1] = mk(8, 2, 1, 3, 2, 3);
    dir[2] = mk(16, 2, 1, 3, 2, 3);
    stop_c = mk(5, 4, 2, 0, 3, 4);

    cur = dir[0];
    apply(cur);
    en = 1'b1;
    wait_vs(n);
    chk("start_latency", 32'(n), 32'(2));
    prev_fg0 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 2)      nxt = dir[i + 1];
      else if (i < 8) nxt = rnd_cfg();
      else            nxt = stop_c;
      check_frame(cur, nxt, -1, prev_fg0);
      prev_fg0 = (cur.fg == 0);
      cur = nxt;
    end
    // en drops during line 1; the frame still completes and the block idles.
    check_frame(cur, cur, cur.w * (cur.dg + 1) + cur.lg + 1, prev_fg0);
    any_de = 1'b0; any_busy = 1'b0; any_fd = 1'b0;
    repeat (30) begin
      any_de   |= de_o;
      any_busy |= busy_o;
      any_fd   |= frame_done_o;
      @(negedge clk);
    end
    chk("post_stop_de", 32'(any_de), 32'(0));
    chk("post_stop_busy", 32'(any_busy), 32'(0));
    chk("post_stop_fd", 32'(any_fd), 32'(0));

    // Zero width keeps the block idle even with en high.
    apply(mk(0, 3, 1, 0, 0, 0));
    en = 1'b1;
    any_de = 1'b0; any_busy = 1'b0;
    repeat (100) begin
      @(negedge clk);
      any_de   |= de_o;
      any_busy |= busy_o;
    end
    chk("zero_w_de", 32'(any_de), 32'(0));
    chk("zero_w_busy", 32'(any_busy), 32'(0));

    // Reset in the middle of a line, then restart from the origin.
    rst_c = mk(12, 3, 3, 1, 2, 2);
    apply(rst_c);
    wait_vs(n);
    chk("restart_latency", 32'(n), 32'(2));
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", 32'(busy_o), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_do", 32'(do_o), 32'(0));
    chk("midrst_de", 32'(de_o), 32'(0));
    chk("midrst_hs", 32'(hs_o), 32'(0));
    chk("midrst_vs", 32'(vs_o), 32'(0));
    chk("midrst_busy", 32'(busy_o), 32'(0));
    chk("midrst_fd", 32'(frame_done_o), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    wait_vs(n);
    chk("post_rst_latency", 32'(n), 32'(2));
    check_frame(rst_c, rst_c, 1, 1'b0);
    repeat (3) @(negedge clk);
    chk("final_idle_busy", 32'(busy_o), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_pattern_src.md
# video_pattern_src

Synthesizable video stream source for the scaler pipeline: emits pixels on `do_o/de_o/hs_o/vs_o` in exactly the pulse-sync format that `scaler_h` consumes. It replaces the BMP-driven stimulus in hardware bring-up and feeds the scaler chain from a built-in test pattern at configurable size and pacing. It sits at the head of the video path, upstream of the horizontal scaler.

## Interface

Parameters:
- `PIXEL_WIDTH`, 8 — pixel data width.
- `DIM_WIDTH`, 16 — width of size and gap configuration inputs.

Ports:
- `clk` in 1 — single clock; all logic on the rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `en` in 1 — run request; sampled only in IDLE and at frame end.
- `img_w` in DIM_WIDTH — pixels per line.
- `img_h` in DIM_WIDTH — lines per frame.
- `pattern` in 2 — pattern select: 0 diagonal, 1 h-ramp, 2 v-ramp, 3 checker.
- `de_gap` in 4 — empty cycles after each pixel; 0 means one pixel per cycle.
- `line_gap` in DIM_WIDTH — de-low cycles between lines.
- `frame_gap` in DIM_WIDTH — de-low cycles after the last line of a frame.
- `do_o` out PIXEL_WIDTH — pixel data; valid only when `de_o` is high.
- `de_o` out 1 — pixel valid.
- `hs_o` out 1 — one-cycle pulse coincident with the first pixel of each line.
- `vs_o` out 1 — one-cycle pulse coincident with the first pixel of each frame; `hs_o` is also high in that cycle.
- `busy_o` out 1 — high from frame start until the frame gap completes.
- `frame_done_o` out 1 — one-cycle pulse in the first frame-gap cycle.

## Operation

- FSM states:
  - IDLE → ACTIVE when `en`=1, `img_w`≠0 and `img_h`≠0. On this transition, latch `img_w`, `img_h`, `pattern`, `de_gap`, `line_gap` and `frame_gap` into shadow registers. Inputs may change at any time afterwards without effect until the next frame start.
  - ACTIVE: each pixel slot lasts `de_gap`+1 cycles. `de_o`=1 in the first cycle of the slot and 0 in the remaining `de_gap` cycles. After slot `img_w`-1:
    - if y < h-1: go to LGAP;
    - else: go to FGAP.
  - LGAP: `line_gap` cycles with `de_o`=0, then go to ACTIVE with y+1 and x=0. If `line_gap`=0, go straight to the next line.
  - FGAP: `frame_gap` cycles, then:
    - if `en`=1 and the new sizes are non-zero: re-latch config and go to ACTIVE (back-to-back frames);
    - else: go to IDLE.
    - If `frame_gap`=0, this decision is made in the same cycle the state is entered.
- Counters x and y are DIM_WIDTH bits and reset to 0 at frame start.
- Pixel value, truncated to PIXEL_WIDTH:
  - diagonal: x+y;
  - h-ramp: x;
  - v-ramp: y;
  - checker: all bits equal to x[3]^y[3].
- Dropping `en` mid-frame has no effect; the current frame completes, including its frame gap.
- Zero width or height while in IDLE: the block stays in IDLE and emits nothing.
- `do_o` holds its last value when `de_o`=0.

## Timing

- All outputs are registered.
- Reset values: `do_o`=0, `de_o`=0, `hs_o`=0, `vs_o`=0, `busy_o`=0, `frame_done_o`=0. State is IDLE and counters are 0.
- Reset asserted mid-frame forces all outputs to 0 asynchronously. After reset the block stays in IDLE until `en` is sampled high.
- Start latency: `en` sampled high at edge k (in IDLE) → first pixel with `de_o`=`hs_o`=`vs_o`=1 and `busy_o`=1 after edge k+1.
- Line period: `img_w`·(`de_gap`+1) + `line_gap` cycles.
- Frame period: `img_h`·`img_w`·(`de_gap`+1) + (`img_h`-1)·`line_gap` + `frame_gap` cycles.
- `busy_o` falls on the edge that enters IDLE.
- `hs_o` and `vs_o` never assert without `de_o`.

## Structure

- Package `video_pkg` holds:
  - `pattern_t` enum (DIAG, HRAMP, VRAMP, CHECK);
  - `vps_state_t` enum (IDLE, ACTIVE, LGAP, FGAP).
- One sub-module, `video_pattern_pix`: a combinational function of pattern, x and y that produces the pixel value. The FSM, counters and output registers stay in the top module.

## Test plan

- Config 4×3, diagonal, `de_gap`=0, `line_gap`=2, `frame_gap`=5, `en` held high:
  - pixels per line: 0,1,2,3 / 1,2,3,4 / 2,3,4,5;
  - `hs_o` pulses 3 per frame;
  - `vs_o` on the first pixel only;
  - frame period 4·3+2·2+5 = 21 cycles.
- `de_gap`=3, `img_w`=8, h-ramp: `de_o` is high every 4th cycle with values 0..7, and the line spans 32 cycles.
- Change `img_w` from 8 to 16 mid-frame: the current frame keeps 8 pixels per line and the next frame uses 16.
- Deassert `en` during line 1 of a 4-line frame:
  - all 4 lines still complete;
  - `frame_done_o` pulses once;
  - `busy_o` drops after the frame gap;
  - no further `de_o`.
- `img_w`=0 with `en`=1: the block stays in IDLE, `busy_o`=0, and no `de_o` for 100 cycles.
- Assert `rst_n`=0 mid-line: all outputs are 0 in the same cycle. After release with `en`=1, the next frame restarts at x=y=0 with `vs_o`=1.
